// File: rtl/uart_cmd_framer_pkg.sv
// Shared definitions for the UART command path: packet layout, opcodes and framer states.
// Imported by uart_cmd_framer, cmd_dispatcher and the testbench.
package uart_cmd_framer_pkg;

    localparam logic [7:0] OPC_READ  = 8'h01;
    localparam logic [7:0] OPC_WRITE = 8'h02;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_packet_t;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_OPCODE,
        ST_ADDR,
        ST_DATA,
        ST_CHK
    } framer_state_e;

    function automatic logic opcode_valid(input logic [7:0] opc);
        return (opc == OPC_READ) || (opc == OPC_WRITE);
    endfunction

endpackage

// File: rtl/uart_cmd_framer_if.sv
// Byte stream from uart_rx plus the cmd_fifo write port, as seen by the framer.
// master = stream/FIFO side, slave = framer.
interface uart_cmd_framer_if;
    import uart_cmd_framer_pkg::*;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        cmd_fifo_full;
    logic        cmd_wr_en;
    cmd_packet_t cmd_wr_data;

    modport master (
        output rx_data, rx_valid, rx_frame_err, cmd_fifo_full,
        input  cmd_wr_en, cmd_wr_data
    );

    modport slave (
        input  rx_data, rx_valid, rx_frame_err, cmd_fifo_full,
        output cmd_wr_en, cmd_wr_data
    );

endinterface

// File: rtl/uart_cmd_framer_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles 5-byte command frames (sync, opcode, addr, data, chk) from the uart_rx stream,
// validates them and pushes good ones into cmd_fifo; resyncs on hunt, timeout or stop-bit error.
//
// state     | meaning
// ST_HUNT   | waiting for SYNC_BYTE, idle timer parked
// ST_OPCODE | next byte is the opcode
// ST_ADDR   | next byte is the address
// ST_DATA   | next byte is the data
// ST_CHK    | next byte is the checksum; frame verdict is made here
module uart_cmd_framer
    import uart_cmd_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_framer_if.slave     bus,
    output logic [CNT_WIDTH-1:0] chk_err_cnt_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    output logic [CNT_WIDTH-1:0] timeout_cnt_o
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    framer_state_e state_q, state_d;
    logic [7:0]    opc_q, opc_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic          wr_en_q, wr_en_d;
    cmd_packet_t   wr_data_q, wr_data_d;
    logic          chk_inc, drop_inc, to_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HUNT;
            opc_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            idle_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            idle_q    <= idle_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        addr_d    = addr_q;
        data_d    = data_q;
        idle_d    = idle_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        chk_inc   = 1'b0;
        drop_inc  = 1'b0;
        to_inc    = 1'b0;

        if (state_q == ST_HUNT) begin
            idle_d = '0;
            // a byte flagged with a stop-bit error never starts a frame
            if (bus.rx_valid && !bus.rx_frame_err && (bus.rx_data == SYNC_BYTE)) begin
                state_d = ST_OPCODE;
            end
        end else if (bus.rx_frame_err) begin
            state_d = ST_HUNT;
            idle_d  = '0;
            to_inc  = 1'b1;
        end else if (bus.rx_valid) begin
            idle_d = '0;
            case (state_q)
                ST_OPCODE: begin
                    opc_d   = bus.rx_data;
                    state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_d  = bus.rx_data;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    data_d  = bus.rx_data;
                    state_d = ST_CHK;
                end
                ST_CHK: begin
                    state_d = ST_HUNT;
                    if (opcode_valid(opc_q) && ((opc_q ^ addr_q ^ data_q) == bus.rx_data)) begin
                        if (bus.cmd_fifo_full) begin
                            drop_inc = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = '{cmd: opc_q, addr: addr_q, data: data_q};
                        end
                    end else begin
                        chk_inc = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end else if (idle_q == IDLE_LAST) begin
            state_d = ST_HUNT;
            idle_d  = '0;
            to_inc  = 1'b1;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    assign bus.cmd_wr_en   = wr_en_q;
    assign bus.cmd_wr_data = wr_data_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_chk_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (chk_inc),
        .cnt_o (chk_err_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (to_inc),
        .cnt_o (timeout_cnt_o)
    );

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: directed frames from the test plan plus random byte streams,
// checked every cycle against a frame-level reference model.
module tb_uart_cmd_framer;
    import uart_cmd_framer_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_framer_if bus_if ();
    logic [7:0] chk_err_cnt, drop_cnt, timeout_cnt;

    uart_cmd_framer #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if.slave),
        .chk_err_cnt_o (chk_err_cnt),
        .drop_cnt_o    (drop_cnt),
        .timeout_cnt_o (timeout_cnt)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: the partial frame is just the list of bytes collected so far
    logic [7:0]  m_frame[$];
    int          m_idle;
    int          m_chk, m_drop, m_to;
    bit          m_wr;
    cmd_packet_t m_last;

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic model_reset();
        m_frame.delete();
        m_idle = 0;
        m_chk  = 0;
        m_drop = 0;
        m_to   = 0;
        m_wr   = 1'b0;
        m_last = '0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit fe, input bit full);
        bit in_frame;
        in_frame = (m_frame.size() > 0);
        m_wr = 1'b0;
        if (in_frame && fe) begin
            m_frame.delete();
            m_to = sat_inc(m_to);
        end else if (v) begin
            m_idle = 0;
            if (!in_frame) begin
                if (!fe && b == 8'hA5) m_frame.push_back(b);
            end else begin
                m_frame.push_back(b);
                if (m_frame.size() == 5) begin
                    if ((m_frame[1] == 8'h01 || m_frame[1] == 8'h02) &&
                        ((m_frame[1] ^ m_frame[2] ^ m_frame[3]) == m_frame[4])) begin
                        if (full) m_drop = sat_inc(m_drop);
                        else begin
                            m_wr   = 1'b1;
                            m_last = '{cmd: m_frame[1], addr: m_frame[2], data: m_frame[3]};
                        end
                    end else begin
                        m_chk = sat_inc(m_chk);
                    end
                    m_frame.delete();
                end
            end
        end else if (in_frame) begin
            if (m_idle == TMO - 1) begin
                m_frame.delete();
                m_to = sat_inc(m_to);
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("wr_en",   32'(bus_if.cmd_wr_en),   32'(m_wr));
        check_val("wr_data", 32'(bus_if.cmd_wr_data), 32'(m_last));
        check_val("chk_cnt", 32'(chk_err_cnt), 32'(m_chk));
        check_val("drop_cnt", 32'(drop_cnt),   32'(m_drop));
        check_val("to_cnt",  32'(timeout_cnt), 32'(m_to));
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit fe, input bit full);
        bus_if.rx_valid      = v;
        bus_if.rx_data       = b;
        bus_if.rx_frame_err  = fe;
        bus_if.cmd_fifo_full = full;
        @(posedge clk);
        model_step(v, b, fe, full);
        #1;
        check_outputs();
        bus_if.rx_valid      = 1'b0;
        bus_if.rx_frame_err  = 1'b0;
        bus_if.cmd_fifo_full = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] ad, input logic [7:0] da,
                              input logic [7:0] ck, input bit full_on_chk, input int gap);
        send(8'hA5);   idle(gap);
        send(op);      idle(gap);
        send(ad);      idle(gap);
        send(da);      idle(gap);
        cycle(1'b1, ck, 1'b0, full_on_chk);
    endtask

    initial begin
        logic [7:0] q[$];
        bus_if.rx_valid      = 1'b0;
        bus_if.rx_data       = 8'h00;
        bus_if.rx_frame_err  = 1'b0;
        bus_if.cmd_fifo_full = 1'b0;
        model_reset();

        #12;
        check_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // good write
        send_frame(8'h02, 8'h10, 8'h3C, 8'h2E, 1'b0, 0);
        idle(1);
        // bad checksum then bad opcode
        send_frame(8'h01, 8'h20, 8'h00, 8'h00, 1'b0, 0);
        check_val("plan_chk1", 32'(chk_err_cnt), 32'd1);
        send_frame(8'h07, 8'h00, 8'h00, 8'h07, 1'b0, 1);
        check_val("plan_chk2", 32'(chk_err_cnt), 32'd2);
        // garbage before sync
        send(8'hFF); send(8'h13);
        send_frame(8'h01, 8'h20, 8'h00, 8'h21, 1'b0, 0);
        // fifo full on chk, then accepted
        send_frame(8'h02, 8'h44, 8'h55, 8'h13, 1'b1, 0);
        check_val("plan_drop", 32'(drop_cnt), 32'd1);
        send_frame(8'h02, 8'h44, 8'h55, 8'h13, 1'b0, 0);
        // timeout mid-frame, then a good frame
        send(8'hA5); send(8'h02); idle(20);
        check_val("plan_to1", 32'(timeout_cnt), 32'd1);
        send_frame(8'h01, 8'h0F, 8'h99, 8'h97, 1'b0, 0);
        // byte landing exactly on the expiry cycle is still taken
        send_frame(8'h02, 8'h01, 8'hA5, 8'hA6, 1'b0, TMO - 1);
        check_val("plan_to_edge", 32'(timeout_cnt), 32'd1);
        // stop-bit error on the addr byte
        send(8'hA5); send(8'h02); cycle(1'b1, 8'h30, 1'b1, 1'b0);
        check_val("plan_to2", 32'(timeout_cnt), 32'd2);
        send_frame(8'h02, 8'h30, 8'h01, 8'h33, 1'b0, 0);
        // stop-bit error on a sync byte while hunting is ignored
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        send(8'h02); send(8'h02); send(8'h00); send(8'h00); idle(TMO + 2);

        // random streams
        for (int i = 0; i < 80; i++) begin
            int kind;
            int ferr_at;
            logic [7:0] op, ad, da;
            kind = $urandom_range(0, 5);
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 2));
            ad = 8'($urandom_range(0, 255));
            da = 8'($urandom_range(0, 255));
            q.delete();
            case (kind)
                0, 5: q = '{8'hA5, op, ad, da, op ^ ad ^ da};
                1: q = '{8'hA5, op, ad, da, (op ^ ad ^ da) ^ 8'($urandom_range(1, 255))};
                2: q = '{8'hA5, 8'($urandom_range(3, 255)), ad, da, 8'($urandom_range(3, 255)) ^ ad ^ da};
                3: q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
                default: q = '{8'hA5, op};
            endcase
            ferr_at = (kind == 5) ? $urandom_range(0, 4) : -1;
            foreach (q[j]) begin
                int gap;
                cycle(1'b1, q[j], (j == ferr_at), ($urandom_range(0, 3) == 0));
                case ($urandom_range(0, 9))
                    0: gap = TMO - 1;
                    1: gap = TMO;
                    default: gap = $urandom_range(0, 3);
                endcase
                if (j != q.size() - 1) idle(gap);
            end
            idle((kind == 4) ? TMO + 1 : $urandom_range(0, 2));
        end

        // saturation
        for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h00, 8'h00, 8'h55, 1'b0, 0);
        check_val("chk_sat", 32'(chk_err_cnt), 32'hFF);
        send_frame(8'h02, 8'h77, 8'h66, 8'h13, 1'b0, 0);

        // asynchronous reset mid-frame
        send(8'hA5); send(8'h02); send(8'h10);
        #3 rst = 1'b1;
        #1;
        check_val("rst_wr_en",   32'(bus_if.cmd_wr_en),   32'd0);
        check_val("rst_wr_data", 32'(bus_if.cmd_wr_data), 32'd0);
        check_val("rst_chk",     32'(chk_err_cnt), 32'd0);
        check_val("rst_drop",    32'(drop_cnt),    32'd0);
        check_val("rst_to",      32'(timeout_cnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h3C); send(8'h2E); idle(2);
        send_frame(8'h02, 8'h10, 8'h3C, 8'h2E, 1'b0, 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
